// File: rtl/arb_weighted_rr.sv
// Weighted round-robin arbiter: the owner keeps the grant for up to its weight in
// consecutive cycles, then priority rotates to the next source with no idle bubble.
module arb_weighted_rr #(
    parameter  int REQ_NUM  = 4,
    parameter  int WEIGHT_W = 4,
    localparam int IDX_W    = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [REQ_NUM-1:0]           req,
    input  logic [REQ_NUM*WEIGHT_W-1:0]  weight,
    output logic [REQ_NUM-1:0]           grant,
    output logic [IDX_W-1:0]             grant_idx,
    output logic                         busy
);

    localparam logic [IDX_W:0]    LP_NUM_EXT = (IDX_W+1)'(REQ_NUM);
    localparam logic [IDX_W-1:0]  LP_LAST    = IDX_W'(REQ_NUM - 1);
    localparam logic [IDX_W-1:0]  LP_IDX_ONE = IDX_W'(1);
    localparam logic [WEIGHT_W-1:0] LP_W_ONE = WEIGHT_W'(1);

    logic [REQ_NUM-1:0]   r_grant;
    logic [IDX_W-1:0]     r_grant_idx;
    logic [IDX_W-1:0]     r_ptr;
    logic [WEIGHT_W-1:0]  r_cnt;
    logic [WEIGHT_W-1:0]  r_lim;

    logic                 w_busy;
    logic                 w_owner_req;
    logic                 w_term;
    logic                 w_arb;
    logic [IDX_W-1:0]     w_owner_nxt;
    logic [IDX_W-1:0]     w_start;
    logic [2*REQ_NUM-1:0] w_req_dbl;
    logic [REQ_NUM-1:0]   w_req_rot;
    logic                 w_pick_valid;
    logic [IDX_W:0]       w_pick_off;
    logic [IDX_W:0]       w_pick_sum;
    logic [IDX_W-1:0]     w_pick_idx;
    logic [WEIGHT_W-1:0]  w_pick_wt;
    logic [WEIGHT_W-1:0]  w_pick_lim;
    logic [REQ_NUM-1:0]   w_pick_onehot;

    assign w_busy      = |r_grant;
    assign w_owner_req = |(req & r_grant);
    assign w_term      = w_busy && (!w_owner_req || (r_cnt == r_lim));
    assign w_arb       = !w_busy || w_term;

    // After a burst the search begins just past the owner, so the owner itself is checked last.
    assign w_owner_nxt = (r_grant_idx == LP_LAST) ? '0 : r_grant_idx + LP_IDX_ONE;
    assign w_start     = w_busy ? w_owner_nxt : r_ptr;

    // Rotating a doubled request vector puts the search start at bit 0.
    assign w_req_dbl = {req, req};
    assign w_req_rot = REQ_NUM'(w_req_dbl >> w_start);

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        w_pick_valid = 1'b0;
        w_pick_off   = '0;
        for (int k = REQ_NUM - 1; k >= 0; k--) begin
            if (w_req_rot[k]) begin
                w_pick_valid = 1'b1;
                w_pick_off   = (IDX_W+1)'(k);
            end
        end
    end

    assign w_pick_sum = {1'b0, w_start} + w_pick_off;
    assign w_pick_idx = (w_pick_sum >= LP_NUM_EXT) ? IDX_W'(w_pick_sum - LP_NUM_EXT)
                                                   : w_pick_sum[IDX_W-1:0];

    always_comb begin
        w_pick_wt     = '0;
        w_pick_onehot = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (w_pick_idx == IDX_W'(i)) begin
                w_pick_wt        = weight[i*WEIGHT_W +: WEIGHT_W];
                w_pick_onehot[i] = 1'b1;
            end
        end
    end

    // A zero weight still earns one cycle per turn.
    assign w_pick_lim = (w_pick_wt == '0) ? LP_W_ONE : w_pick_wt;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant     <= '0;
            r_grant_idx <= '0;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_lim       <= '0;
        end else if (w_arb) begin
            if (w_term) begin
                r_ptr <= w_owner_nxt;
            end
            if (w_pick_valid) begin
                r_grant     <= w_pick_onehot;
                r_grant_idx <= w_pick_idx;
                r_cnt       <= LP_W_ONE;
                r_lim       <= w_pick_lim;
            end else begin
                r_grant     <= '0;
                r_grant_idx <= '0;
                r_cnt       <= '0;
                r_lim       <= '0;
            end
        end else begin
            r_cnt <= r_cnt + LP_W_ONE;
        end
    end

    assign grant     = r_grant;
    assign grant_idx = r_grant_idx;
    assign busy      = w_busy;

endmodule

// File: tb/tb_arb_weighted_rr.sv
// Directed scoreboard checks on a 4-source arbiter plus a randomized fairness and
// one-hot property run on a 5-source, 3-bit-weight instance.
module tb_arb_weighted_rr;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  req4;
    logic [15:0] weight4;
    logic [3:0]  grant4;
    logic [1:0]  idx4;
    logic        busy4;

    logic [4:0]  req5;
    logic [14:0] weight5;
    logic [4:0]  grant5;
    logic [2:0]  idx5;
    logic        busy5;

    arb_weighted_rr #(.REQ_NUM(4), .WEIGHT_W(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req4),
        .weight    (weight4),
        .grant     (grant4),
        .grant_idx (idx4),
        .busy      (busy4)
    );

    arb_weighted_rr #(.REQ_NUM(5), .WEIGHT_W(3)) u_dut5 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req5),
        .weight    (weight5),
        .grant     (grant5),
        .grant_idx (idx5),
        .busy      (busy5)
    );

    typedef struct {
        logic [3:0] grant;
        string      tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;
    int   exp_cnt[4] = '{1, 2, 3, 1};
    int   exp_ptr[4] = '{0, 0, 0, 1};
    int   wait_cnt[5];
    int   bound[5];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] idx_of4(input logic [3:0] g);
        case (g)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic int eff(input int w);
        return (w == 0) ? 1 : w;
    endfunction

    // Outputs are sampled 1 time unit after the rising edge; inputs change right after.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] g, input string tag);
        exp_t e;
        e.grant = g;
        e.tag   = tag;
        sb_q.push_back(e);
    endtask

    task automatic step_check();
        exp_t e;
        step();
        e = sb_q.pop_front();
        check({e.tag, ".grant"}, 32'(grant4), 32'(e.grant));
        check({e.tag, ".idx"},   32'(idx4),   32'(idx_of4(e.grant)));
        check({e.tag, ".busy"},  32'(busy4),  32'(|e.grant));
    endtask

    task automatic drain();
        while (sb_q.size() != 0) step_check();
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        req4  = '0;
        #2;
        check({tag, ".rst_grant"}, 32'(grant4), 0);
        check({tag, ".rst_idx"},   32'(idx4), 0);
        check({tag, ".rst_busy"},  32'(busy4), 0);
        check({tag, ".rst_ptr"},   32'(u_dut4.r_ptr), 0);
        check({tag, ".rst_cnt"},   32'(u_dut4.r_cnt), 0);
        check({tag, ".rst_lim"},   32'(u_dut4.r_lim), 0);
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        req4    = '0;
        weight4 = '0;
        req5    = '0;
        weight5 = '0;
        do_reset("init");

        // Equal weights of 2, all requesting: two cycles each, wrapping 3 -> 0.
        weight4 = 16'h2222;
        req4    = 4'b1111;
        push(4'b0001, "rr0"); push(4'b0001, "rr1"); push(4'b0010, "rr2");
        push(4'b0010, "rr3"); push(4'b0100, "rr4"); push(4'b0100, "rr5");
        push(4'b1000, "rr6"); push(4'b1000, "rr7"); push(4'b0001, "rr8");
        drain();
        req4 = 4'b0000;
        push(4'b0000, "rr_drop");
        drain();
        check("rr_drop.ptr", 32'(u_dut4.r_ptr), 1);
        step();
        step();
        check("idle.ptr_hold", 32'(u_dut4.r_ptr), 1);
        req4 = 4'b1111;
        push(4'b0010, "rr_resume");
        drain();

        // Lone requester with weight 3 keeps the grant; counter reloads after 3.
        do_reset("solo");
        weight4 = 16'h0003;
        req4    = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            push(4'b0001, $sformatf("solo%0d", k));
            step_check();
            check($sformatf("solo%0d.cnt", k), 32'(u_dut4.r_cnt), 32'(exp_cnt[k]));
            check($sformatf("solo%0d.ptr", k), 32'(u_dut4.r_ptr), 32'(exp_ptr[k]));
        end

        // Owner 2 (weight 5) drops after one cycle; source 3 takes over immediately.
        do_reset("drop");
        weight4 = 16'h1511;
        req4    = 4'b0100;
        push(4'b0100, "drop0");
        drain();
        req4 = 4'b1011;
        push(4'b1000, "drop1"); push(4'b0001, "drop2");
        push(4'b0010, "drop3"); push(4'b1000, "drop4");
        drain();

        // Zero weight on source 1 still yields exactly one cycle per turn.
        do_reset("w0");
        weight4 = 16'h2202;
        req4    = 4'b1111;
        push(4'b0001, "w0_0"); push(4'b0001, "w0_1"); push(4'b0010, "w0_2");
        push(4'b0100, "w0_3"); push(4'b0100, "w0_4"); push(4'b1000, "w0_5");
        push(4'b1000, "w0_6"); push(4'b0001, "w0_7"); push(4'b0001, "w0_8");
        push(4'b0010, "w0_9"); push(4'b0100, "w0_10");
        drain();

        // Weight change mid-burst applies only from the next burst.
        do_reset("wchg");
        weight4 = 16'h0014;
        req4    = 4'b0011;
        push(4'b0001, "wchg0");
        drain();
        weight4 = 16'h0011;
        push(4'b0001, "wchg1"); push(4'b0001, "wchg2"); push(4'b0001, "wchg3");
        push(4'b0010, "wchg4"); push(4'b0001, "wchg5"); push(4'b0010, "wchg6");
        drain();

        // Asynchronous reset in the middle of source 3's burst.
        do_reset("mid");
        weight4 = 16'h8111;
        req4    = 4'b1000;
        push(4'b1000, "mid0"); push(4'b1000, "mid1");
        drain();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid.async_grant", 32'(grant4), 0);
        check("mid.async_idx",   32'(idx4), 0);
        check("mid.async_busy",  32'(busy4), 0);
        check("mid.async_ptr",   32'(u_dut4.r_ptr), 0);
        req4 = 4'b1001;
        #1;
        rst_n = 1'b1;
        push(4'b0001, "mid_rel0"); push(4'b1000, "mid_rel1");
        drain();
        req4 = '0;

        // Randomized property run on the 5-source instance.
        for (int seg = 0; seg < 6; seg++) begin
            int total;
            req5 = '0;
            repeat (3) step();
            total = 0;
            for (int i = 0; i < 5; i++) begin
                weight5[i*3 +: 3] = 3'($urandom_range(0, 7));
                total += eff(int'(weight5[i*3 +: 3]));
            end
            for (int i = 0; i < 5; i++) begin
                bound[i]    = total - eff(int'(weight5[i*3 +: 3])) + 1;
                wait_cnt[i] = 0;
            end
            repeat (80) begin
                int e_idx;
                step();
                check("rnd.onehot0", 32'($onehot0(grant5)), 1);
                check("rnd.busy", 32'(busy5), 32'(|grant5));
                e_idx = 0;
                for (int i = 0; i < 5; i++) if (grant5[i]) e_idx = i;
                check("rnd.idx", 32'(idx5), 32'(e_idx));
                for (int i = 0; i < 5; i++) begin
                    if (req5[i] && !grant5[i]) wait_cnt[i]++;
                    else wait_cnt[i] = 0;
                    check($sformatf("rnd.wait%0d_le_%0d", i, bound[i]),
                          32'(wait_cnt[i] <= bound[i]), 1);
                end
                // A waiting source holds its request until served.
                for (int i = 0; i < 5; i++) begin
                    if (!(req5[i] && !grant5[i])) req5[i] = 1'($urandom_range(0, 1));
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
